// File: rtl/open_risc_v_soc.sv
// Single-cycle RV32I core plus unified dual-port word memory for rv32ui regression.
// Optional HALT_ON_ECALL_EN: ECALL holds the PC on itself until reset.
module dual_ram_temp #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] a_idx_i,
  output logic [31:0]   a_data_o,
  input  logic [AW-1:0] b_idx_i,
  output logic [31:0]   b_data_o,
  input  logic [3:0]    b_be_i,
  input  logic [31:0]   b_wdata_i
);
  logic [31:0] memory [0:DEPTH-1];

  assign a_data_o = memory[a_idx_i];
  assign b_data_o = memory[b_idx_i];

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 4; l++)
      if (b_be_i[l]) memory[b_idx_i][l*8 +: 8] <= b_wdata_i[l*8 +: 8];
  end
endmodule

module dual_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] a_idx_i,
  output logic [31:0]   a_data_o,
  input  logic [AW-1:0] b_idx_i,
  output logic [31:0]   b_data_o,
  input  logic [3:0]    b_be_i,
  input  logic [31:0]   b_wdata_i
);
  dual_ram_temp #(.DEPTH(DEPTH), .AW(AW)) dual_ram_temp_inst (.*);
endmodule

module rom #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] a_idx_i,
  output logic [31:0]   a_data_o,
  input  logic [AW-1:0] b_idx_i,
  output logic [31:0]   b_data_o,
  input  logic [3:0]    b_be_i,
  input  logic [31:0]   b_wdata_i
);
  dual_ram #(.DEPTH(DEPTH), .AW(AW)) rom_mem (.*);
endmodule

module regs (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);
  logic [31:0] regss [0:31];

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regss[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regss[ra2_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regss[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      regss[wa_i] <= wd_i;
    end
  end
endmodule

module open_risc_v #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic [AW-1:0] imem_idx_o,
  input  logic [31:0]   instr_i,
  output logic [AW-1:0] dmem_idx_o,
  input  logic [31:0]   dmem_rdata_i,
  output logic [3:0]    dmem_be_o,
  output logic [31:0]   dmem_wdata_o
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR  = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33;
`ifdef HALT_ON_ECALL_EN
  localparam logic [31:0] ECALL = 32'h0000_0073;
`endif

  logic [31:0] pc_q, pc_d, rs1, rs2, rd_wd, alu_res, alu_b, ls_addr, jalr_t, st_data;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [3:0]  st_be;
  logic        rd_we, br_take, unused;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  regs regs_inst (
    .clk_i, .rst_ni, .ra1_i(instr_i[19:15]), .ra2_i(instr_i[24:20]),
    .rd1_o(rs1), .rd2_o(rs2), .we_i(rd_we), .wa_i(instr_i[11:7]), .wd_i(rd_wd)
  );

  assign ls_addr    = rs1 + ((opc == OP_ST) ? imm_s : imm_i);
  assign jalr_t     = rs1 + imm_i;
  assign imem_idx_o = pc_q[AW+1:2];
  assign dmem_idx_o = ls_addr[AW+1:2];
  assign unused     = ^{pc_q[31:AW+2], pc_q[1:0], ls_addr[31:AW+2]};
  assign ld_byte    = dmem_rdata_i[{ls_addr[1:0], 3'b000} +: 8];
  assign ld_half    = ls_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  // Register-form SUB/SRA and immediate-form SRAI both key off instr[30].
  assign alu_b = (opc == OP_REG) ? rs2 : imm_i;
  always_comb begin
    case (f3)
      3'd0:    alu_res = (opc == OP_REG && instr_i[30]) ? rs1 - alu_b : rs1 + alu_b;
      3'd1:    alu_res = rs1 << alu_b[4:0];
      3'd2:    alu_res = {31'b0, $signed(rs1) < $signed(alu_b)};
      3'd3:    alu_res = {31'b0, rs1 < alu_b};
      3'd4:    alu_res = rs1 ^ alu_b;
      3'd5:    alu_res = instr_i[30] ? 32'($signed(rs1) >>> alu_b[4:0]) : rs1 >> alu_b[4:0];
      3'd6:    alu_res = rs1 | alu_b;
      default: alu_res = rs1 & alu_b;
    endcase
  end

  always_comb begin
    case (f3)
      3'd0:    br_take = (rs1 == rs2);
      3'd1:    br_take = (rs1 != rs2);
      3'd4:    br_take = ($signed(rs1) < $signed(rs2));
      3'd5:    br_take = ($signed(rs1) >= $signed(rs2));
      3'd6:    br_take = (rs1 < rs2);
      3'd7:    br_take = (rs1 >= rs2);
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    pc_d    = pc_q + 32'd4;
    rd_we   = 1'b0;
    rd_wd   = alu_res;
    st_be   = 4'b0;
    st_data = rs2;
    case (opc)
      OP_LUI:   begin rd_we = 1'b1; rd_wd = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_wd = pc_q + imm_u; end
      OP_JAL:   begin rd_we = 1'b1; rd_wd = pc_q + 32'd4; pc_d = pc_q + imm_j; end
      OP_JALR:  begin rd_we = 1'b1; rd_wd = pc_q + 32'd4; pc_d = {jalr_t[31:1], 1'b0}; end
      OP_BR:    if (br_take) pc_d = pc_q + imm_b;
      OP_LD: begin
        rd_we = 1'b1;
        case (f3)
          3'd0:    rd_wd = {{24{ld_byte[7]}}, ld_byte};
          3'd1:    rd_wd = {{16{ld_half[15]}}, ld_half};
          3'd2:    rd_wd = dmem_rdata_i;
          3'd4:    rd_wd = {24'b0, ld_byte};
          3'd5:    rd_wd = {16'b0, ld_half};
          default: rd_we = 1'b0;
        endcase
      end
      OP_ST: begin
        case (f3)
          3'd0:    begin st_be = 4'b0001 << ls_addr[1:0]; st_data = {4{rs2[7:0]}}; end
          3'd1:    begin st_be = ls_addr[1] ? 4'b1100 : 4'b0011; st_data = {2{rs2[15:0]}}; end
          3'd2:    st_be = 4'b1111;
          default: st_be = 4'b0000;
        endcase
      end
      OP_IMM, OP_REG: rd_we = 1'b1;
      default: begin
`ifdef HALT_ON_ECALL_EN
        // Re-executing ECALL every cycle freezes the core without extra state.
        if (instr_i == ECALL) pc_d = pc_q;
`endif
      end
    endcase
  end

  // Stores are suppressed for as long as reset is held.
  assign dmem_be_o    = st_be & {4{rst_ni}};
  assign dmem_wdata_o = st_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end
endmodule

module open_risc_v_soc #(
  parameter int          MEM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset_n
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [AW-1:0] imem_idx, dmem_idx;
  logic [31:0]   instr, dmem_rdata, dmem_wdata;
  logic [3:0]    dmem_be;

  open_risc_v #(.RESET_PC(RESET_PC), .AW(AW)) open_risc_v_inst (
    .clk_i(clk), .rst_ni(reset_n), .imem_idx_o(imem_idx), .instr_i(instr),
    .dmem_idx_o(dmem_idx), .dmem_rdata_i(dmem_rdata), .dmem_be_o(dmem_be),
    .dmem_wdata_o(dmem_wdata)
  );

  rom #(.DEPTH(MEM_DEPTH), .AW(AW)) rom_inst (
    .clk_i(clk), .a_idx_i(imem_idx), .a_data_o(instr), .b_idx_i(dmem_idx),
    .b_data_o(dmem_rdata), .b_be_i(dmem_be), .b_wdata_i(dmem_wdata)
  );
endmodule

// File: tb/tb_open_risc_v_soc.sv
// Scoreboarded bench: each program pushes its expected register results, then drains them after it runs.
module tb_open_risc_v_soc;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  open_risc_v_soc dut (.clk(clk), .reset_n(reset_n));

  typedef struct { string tag; int idx; logic [31:0] val; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] prog[$];
  int n_tests = 0;
  int n_fail  = 0;
  localparam logic [31:0] HALT = 32'h0000_006f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ei(int imm, int rs1, int f3, int rd, int op);
    return 32'(((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
  endfunction
  function automatic logic [31:0] er(int f7, int rs2, int rs1, int f3, int rd);
    return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33);
  endfunction
  function automatic logic [31:0] es(int imm, int rs2, int rs1, int f3);
    return 32'((((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
               | ((imm & 'h1F) << 7) | 'h23);
  endfunction
  function automatic logic [31:0] eb(int imm, int rs2, int rs1, int f3);
    return 32'((((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
               | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 'hF) << 8)
               | (((imm >> 11) & 1) << 7) | 'h63);
  endfunction
  function automatic logic [31:0] ej(int imm, int rd);
    return 32'((((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21)
               | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F);
  endfunction
  function automatic logic [31:0] eu(int imm20, int rd, int op);
    return 32'((imm20 << 12) | (rd << 7) | op);
  endfunction

  task automatic exp_reg(input string tag, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.idx = idx; e.val = v;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] regs_or();
    logic [31:0] acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.open_risc_v_inst.regs_inst.regss[i];
    return acc;
  endfunction

  // Load prog under reset, release, run a bounded number of cycles, sample on the falling edge.
  task automatic load_and_run(input int cycles);
    reset_n = 1'b0;
    for (int i = 0; i < 64; i++)
      dut.rom_inst.rom_mem.dual_ram_temp_inst.memory[i] = (i < prog.size()) ? prog[i] : HALT;
    #30;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, dut.open_risc_v_inst.regs_inst.regss[e.idx], e.val);
    end
  endtask

  initial begin
    // Power-on reset
    #30;
    check("rst_pc", dut.open_risc_v_inst.pc_q, 32'h0);
    check("rst_regs", regs_or(), 32'h0);

    // ALU
    prog = '{ei(5,0,0,1,'h13), ei(-3,0,0,2,'h13), er(0,2,1,0,3), er('h20,2,1,0,4),
             ei('h401,2,5,5,'h13), er(0,1,2,2,6), er(0,1,2,3,7), ei(-1,2,4,8,'h13),
             ei(28,2,5,9,'h13), ei(31,1,1,10,'h13), eu('h12345,11,'h37), eu(1,12,'h17),
             ei(33,0,0,14,'h13), er(0,14,1,1,13), HALT};
    exp_reg("add", 3, 32'h2);          exp_reg("sub", 4, 32'h8);
    exp_reg("srai", 5, 32'hFFFF_FFFE); exp_reg("slt", 6, 32'h1);
    exp_reg("sltu", 7, 32'h0);         exp_reg("xori", 8, 32'h2);
    exp_reg("srli", 9, 32'hF);         exp_reg("slli", 10, 32'h8000_0000);
    exp_reg("lui", 11, 32'h1234_5000); exp_reg("auipc", 12, 32'h0000_102C);
    exp_reg("sll_5b", 13, 32'hA);
    load_and_run(20);
    drain();
    check("halt_pc", dut.open_risc_v_inst.pc_q, 32'h38);

    // Asynchronous reset mid-program, away from any clock edge
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_pc", dut.open_risc_v_inst.pc_q, 32'h0);
    check("arst_regs", regs_or(), 32'h0);

    // Load/store lanes, wrap and misaligned word access
    prog = '{eu(2,1,'h37), eu('h12345,2,'h37), ei('h678,2,0,2,'h13), es(0,2,1,2),
             ei('hAA,0,0,3,'h13), es(1,3,1,0), ei(0,1,2,4,'h03), ei(1,1,0,5,'h03),
             ei(2,1,5,6,'h03), ei(1,1,4,7,'h03), ei(0,1,1,8,'h03), es(2,3,1,1),
             ei(0,1,2,9,'h03), eu(4,10,'h37), ei(0,10,2,11,'h03), ei(3,1,2,12,'h03), HALT};
    exp_reg("lw_sb", 4, 32'h1234_AA78); exp_reg("lb", 5, 32'hFFFF_FFAA);
    exp_reg("lhu", 6, 32'h0000_1234);   exp_reg("lbu", 7, 32'h0000_00AA);
    exp_reg("lh", 8, 32'hFFFF_AA78);    exp_reg("lw_sh", 9, 32'h00AA_AA78);
    exp_reg("lw_wrap", 11, prog[0]);    exp_reg("lw_misal", 12, 32'h00AA_AA78);
    load_and_run(25);
    drain();
    check("mem_word", dut.rom_inst.rom_mem.dual_ram_temp_inst.memory[2048], 32'h00AA_AA78);

    // Control flow
    prog = '{ei(1,0,0,1,'h13), eb(8,0,1,1), ei(99,0,0,2,'h13), ej(8,3), ei(77,0,0,4,'h13),
             ei(33,0,0,5,'h13), ei(0,5,0,6,'h67), ei(55,0,0,7,'h13), ei(5,0,0,0,'h13),
             eb(8,0,1,0), ei(66,0,0,8,'h13), ei(-1,0,0,9,'h13), eb(8,1,9,4), ei(1,0,0,10,'h13),
             eb(8,1,9,6), ei(2,0,0,11,'h13), eb(8,9,1,5), ei(3,0,0,12,'h13), eb(8,9,1,7),
             ei(4,0,0,13,'h13), HALT};
    exp_reg("bne_skip", 2, 32'h0);  exp_reg("jal_ra", 3, 32'd16);
    exp_reg("jal_skip", 4, 32'h0);  exp_reg("jalr_ra", 6, 32'd28);
    exp_reg("jalr_odd", 7, 32'h0);  exp_reg("x0_zero", 0, 32'h0);
    exp_reg("beq_nt", 8, 32'd66);   exp_reg("blt_tk", 10, 32'h0);
    exp_reg("bltu_nt", 11, 32'd2);  exp_reg("bge_tk", 12, 32'h0);
    exp_reg("bgeu_nt", 13, 32'd4);
    load_and_run(30);
    drain();
    check("cf_pc", dut.open_risc_v_inst.pc_q, 32'd80);

    // ECALL at 0x40
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(ei(1,1,0,1,'h13));
    prog.push_back(32'h0000_0073);
    prog.push_back(ei(7,0,0,2,'h13));
    prog.push_back(HALT);
    exp_reg("ecall_x1", 1, 32'd16);
`ifdef HALT_ON_ECALL_EN
    exp_reg("ecall_x2", 2, 32'h0);
    load_and_run(120);
    check("ecall_pc", dut.open_risc_v_inst.pc_q, 32'h40);
`else
    exp_reg("ecall_x2", 2, 32'd7);
    load_and_run(120);
    check("ecall_pc", dut.open_risc_v_inst.pc_q, 32'h48);
`endif
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/open_risc_v_soc.md
Name: open_risc_v_soc

Overview:
- Self-contained RV32I system-on-chip for simulation regression with the riscv-tests rv32ui suite.
- Contains one non-pipelined, single-cycle RV32I core and one unified dual-port word memory. The memory is loaded with the test program and also serves data.
- No external buses. The bench observes completion through the register file, using the riscv-tests convention: x26=1 means done, x27=1 means pass.

Parameters:
- MEM_DEPTH, 4096: number of 32-bit words in the unified memory (16 KiB).
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.

Behaviour:
- Fixed hierarchy, for bench backdoor access:
  - open_risc_v_inst.regs_inst.regss[0:31] is the 32x32 register file.
  - rom_inst.rom_mem.dual_ram_temp_inst.memory[0:MEM_DEPTH-1] is the 32-bit memory array, loadable with $readmemh, word 0 at byte address 0.
- Reset while reset_n=0, asynchronous and at any time including mid-program:
  - PC=RESET_PC.
  - All 32 registers = 0.
  - No store is performed.
  - Memory contents are preserved and never cleared.
- Execution: one instruction retires per clk rising edge after reset_n rises. The first instruction executed is at RESET_PC.
- Memory port A (fetch): combinational read of memory[pc[13:2]].
- Memory port B (load/store):
  - Address = rs1 + imm; word index addr[13:2]. Upper address bits are ignored, so addresses wrap modulo 16 KiB.
  - Reads are combinational.
  - Writes are synchronous with per-byte enables.
- Supported instructions:
  - Upper immediates and jumps: LUI, AUIPC, JAL, JALR (target bit 0 cleared).
  - Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - Loads: LB, LH, LW, LBU, LHU.
  - Stores: SB, SH, SW.
  - Immediate ALU: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Register ALU: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Arithmetic:
  - 32-bit wrap-around, with no overflow detection.
  - Shifts use the low 5 bits of the shift amount.
  - Signed compares use two's complement.
- Sub-word access:
  - Byte lane = addr[1:0]. Halfword lane = addr[1].
  - SB writes one lane, SH writes two lanes, SW writes all four.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Misaligned LW/SW use the word at addr[13:2], with the low bits ignored.
- Register file:
  - Two combinational read ports, one synchronous write port.
  - x0 always reads 0; writes to x0 are discarded.
  - Reads of a register being written in the same cycle return the old value, which is correct for single-cycle operation.
- Next PC:
  - Taken branch or jump: PC+imm, or (rs1+imm)&~1 for JALR.
  - Otherwise: PC+4.
  - JAL/JALR write PC+4 to rd.
- FENCE, FENCE.I, CSR ops, MRET, EBREAK, and any unrecognised opcode execute as NOP: PC+4, no register write, no store.
- Store and load to the same word in consecutive cycles: the load sees the stored data.
- Simultaneous fetch and store to the same word: the fetch returns the old contents.

Optional Feature:
- Macro HALT_ON_ECALL_EN.
- Defined: ECALL freezes PC at the ECALL address. No further register or memory writes occur until reset.
- Undefined: ECALL is a NOP (PC+4).

Test Plan:
- Reset: hold reset_n=0 for 30 ns, release, and check regss all 0 and PC=0. Assert reset_n=0 mid-program and check the PC returns to 0 and registers clear asynchronously, without waiting for a clock edge.
- ALU: program "addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x1,x2; sra x5,x2,1" must give x3=2, x4=8, x5=32'hFFFF_FFFE.
- Load/store lanes: sw 32'h1234_5678 at byte 0x2000, then sb 0xAA at 0x2001. Check lw returns 32'h1234_AA78, lb at 0x2001 returns 32'hFFFF_FFAA, and lhu at 0x2002 returns 32'h0000_1234.
- Control flow: check that bne taken skips one instruction; jal x1 stores return address PC+4; jalr to an odd target clears bit 0; a write to x0 leaves x0 at 0.
- Compliance: $readmemh rv32ui-p-sw (and add, lw, beq, ...). Wait for x26==1, then wait 1000 ns, and require x27==1.
- HALT_ON_ECALL_EN: defined, ECALL at 0x40 keeps the PC at 0x40 for 100 cycles with registers unchanged; undefined, the PC advances to 0x44.
